rom_arbiter: RTL and testbench
==============================

// Module: rom_arbiter
// PURPOSE
//  - Shares the single-port synchronous-read program ROM (one registered read per clock) between two masters.
//  - Fetch port: the CPU instruction fetch. Data port: CPU loads from code space (constant tables, lb/lh/lw).
//  - Arbitration rule: data has priority; a starvation counter guarantees fetch progress.
//  - Data port returns byte/half/word extracted and sign- or zero-extended.
// PARAMETERS
//  - ADDR_W       10  byte address width; ROM word index = addr[ADDR_W-1:2]
//  - STARVE_LIMIT 3   consecutive cycles fetch may lose before it is forced to win (1..15)
// PORTS
//  - clk           in   1       system clock
//  - reset         in   1       synchronous, active-high reset
//  - fetch_req     in   1       fetch request; held with fetch_addr until fetch_grant
//  - fetch_addr    in   ADDR_W  fetch byte address (bits[1:0] ignored)
//  - fetch_grant   out  1       combinational; request accepted this cycle
//  - fetch_valid   out  1       one-cycle pulse; fetch_data valid
//  - fetch_data    out  32      instruction word
//  - data_req      in   1       load request; held with addr/size/signed until data_grant
//  - data_addr     in   ADDR_W  load byte address
//  - data_size     in   2       0=byte 1=half 2=word (3 treated as word)
//  - data_signed   in   1       1=sign-extend, 0=zero-extend
//  - data_grant    out  1       combinational; request accepted this cycle
//  - data_valid    out  1       one-cycle pulse; data_rdata valid
//  - data_rdata    out  32      extracted, extended load result
//  - rom_address   out  ADDR_W  to ROM address input (combinational mux)
//  - rom_data_in   in   32      from ROM registered data output
// BEHAVIOUR
//  - Reset: fetch_valid=0, data_valid=0, fetch_data=0, data_rdata=0, owner=NONE, starve_cnt=0.
//  - Issue cycle N: winner's grant=1 and rom_address=winner addr; at most one grant per cycle.
//  - Return cycle N+1: rom_data_in holds the word; the owner register (NONE/FETCH/DATA) routes it.
//    The owner's *_valid pulses for exactly one cycle. Latency is 1 cycle from grant to valid.
//  - Back-to-back grants every cycle are legal; issue and return overlap.
//  - Arbitration:
//    - Only one request: it wins.
//    - Both requests and starve_cnt < STARVE_LIMIT: data wins; starve_cnt++.
//    - Both requests and starve_cnt == STARVE_LIMIT: fetch wins.
//    - Any fetch grant, or fetch_req=0, clears starve_cnt.
//  - No request: rom_address holds its previous value; owner becomes NONE; no valid next cycle.
//  - Data extraction: byte lane = addr[1:0] (byte), addr[1] (half).
//    - Half with addr[0]=1 is aligned down (addr[0] ignored). Word ignores addr[1:0].
//  - Outputs fetch_data/data_rdata are registered and hold their last value between pulses.
//  - Reset asserted mid-transfer: the in-flight return is dropped, no valid pulse, starve_cnt cleared.
//  - Requesters re-request after reset.
//  - Address wrap: addresses beyond ROM depth alias modulo depth (ROM behaviour); the arbiter does not check range.
// CONFIGURATION
//  - ROM_FETCH_CACHE_EN defined: adds a one-entry fetch cache (tag = fetch_addr[ADDR_W-1:2], 32-bit data, valid bit).
//    - Filled on every fetch return. Valid cleared on reset.
//    - fetch_req whose tag matches a valid entry: fetch_grant=1 without using the ROM. fetch_valid=1 next cycle with cached data.
//    - On such a hit the data port may be granted the ROM in the same cycle. A hit counts as a fetch grant (starve_cnt cleared).
//  - Undefined: every fetch uses the ROM; no cache registers exist.
// STRUCTURE
//  - Shared package rom_arbiter_pkg: owner encoding (OWNER_NONE/FETCH/DATA), size codes (SIZE_BYTE/HALF/WORD).
//  - Sub-module rom_load_align: combinational lane select plus sign/zero extension (word, addr[1:0], size, signed -> 32 bits).
// TESTING
//  - Reset, then fetch only: fetch_addr=0x010 -> grant, rom_address=0x010, next cycle fetch_valid=1 with ROM word 4.
//  - Both requests held, STARVE_LIMIT=3: grant pattern D,D,D,F,D,D,D,F...; every fetch_valid follows its grant by 1 cycle.
//  - Byte loads: word 0x8899AABB at word 0; data_addr=0x003 signed -> 0xFFFFFF88; data_addr=0x000 unsigned -> 0x000000BB.
//  - Half loads on the same word: addr=0x002 signed -> 0xFFFF8899; addr=0x001 unsigned -> 0x0000AABB (aligned down).
//  - Reset asserted in the cycle after a data grant -> no data_valid pulse; starve_cnt=0; outputs zero.
//  - ROM_FETCH_CACHE_EN: fetch 0x020 twice with data_req held high. The second fetch hits, and data is granted the ROM in the same cycle.
//    Both valids pulse the next cycle. Without the macro, the second fetch waits per the starvation rule.

Source files
------------

// File: rtl/rom_arbiter_pkg.sv
// Shared types for the ROM arbiter: owner encoding, load size codes and the
// per-load control captured at grant time.
package rom_arbiter_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_FETCH = 2'd1,
    OWNER_DATA  = 2'd2
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic [1:0] lane;
    logic [1:0] size;
    logic       sext;
  } load_ctl_t;

endpackage

// File: rtl/rom_arbiter_if.sv
// Fetch port, data port and ROM connection of the ROM arbiter.
// master = requesters plus the ROM; slave = the arbiter.
interface rom_arbiter_if #(
  parameter int unsigned ADDR_W = 10
);
  import rom_arbiter_pkg::*;

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_grant;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;

  logic              data_req;
  logic [ADDR_W-1:0] data_addr;
  logic [1:0]        data_size;
  logic              data_signed;
  logic              data_grant;
  logic              data_valid;
  logic [DATA_W-1:0] data_rdata;

  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_data_in;

  modport master (
    output fetch_req, fetch_addr, data_req, data_addr, data_size, data_signed, rom_data_in,
    input  fetch_grant, fetch_valid, fetch_data, data_grant, data_valid, data_rdata, rom_address
  );

  modport slave (
    input  fetch_req, fetch_addr, data_req, data_addr, data_size, data_signed, rom_data_in,
    output fetch_grant, fetch_valid, fetch_data, data_grant, data_valid, data_rdata, rom_address
  );

endinterface

// File: rtl/rom_load_align.sv
// Load alignment: selects the byte/half lane of a ROM word and sign- or
// zero-extends it to 32 bits. Half loads ignore addr[0]; words ignore addr[1:0].
module rom_load_align
  import rom_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    half_sel = word_i[15:0];
    rdata_o  = word_i;
    unique case (addr_lo_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
    endcase
    if (addr_lo_i[1]) half_sel = word_i[31:16];
    case (size_i)
      SIZE_BYTE: rdata_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SIZE_HALF: rdata_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default:   rdata_o = word_i;
    endcase
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares a single-port registered-read ROM between instruction fetch and data loads.
// Data has priority; a starvation counter forces a fetch win. ROM_FETCH_CACHE_EN adds a one-entry fetch cache.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic         clk,
  input  logic         reset,
  rom_arbiter_if.slave bus
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  owner_e              owner_q, owner_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  load_ctl_t           ctl_q, ctl_d;
  logic [DATA_W-1:0]   fetch_hold_q, data_hold_q;

  logic                fetch_hit, fetch_rom_win, data_win;
  logic                fetch_ret, data_ret;
  logic [DATA_W-1:0]   fetch_src, load_word;

`ifdef ROM_FETCH_CACHE_EN
  localparam int unsigned TAG_W = ADDR_W - 2;

  logic              cache_valid_q;
  logic [TAG_W-1:0]  cache_tag_q;
  logic [DATA_W-1:0] cache_data_q;
  logic              hit_q;
  logic [DATA_W-1:0] hit_data_q;

  assign fetch_hit = ~reset & bus.fetch_req & cache_valid_q
                   & (cache_tag_q == bus.fetch_addr[ADDR_W-1:2]);

  // Hit data is latched at issue so a same-cycle refill cannot corrupt it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
      hit_q         <= 1'b0;
      hit_data_q    <= '0;
    end else begin
      hit_q      <= fetch_hit;
      hit_data_q <= cache_data_q;
      if (owner_q == OWNER_FETCH) begin
        cache_valid_q <= 1'b1;
        cache_tag_q   <= rom_addr_q[ADDR_W-1:2];
        cache_data_q  <= bus.rom_data_in;
      end
    end
  end

  assign fetch_src = hit_q ? hit_data_q : bus.rom_data_in;
  assign fetch_ret = ~reset & (hit_q | (owner_q == OWNER_FETCH));
`else
  assign fetch_hit = 1'b0;
  assign fetch_src = bus.rom_data_in;
  assign fetch_ret = ~reset & (owner_q == OWNER_FETCH);
`endif

  assign data_ret = ~reset & (owner_q == OWNER_DATA);

  // Arbitration, ROM address mux and next owner.
  always_comb begin
    fetch_rom_win = 1'b0;
    data_win      = 1'b0;
    starve_d      = starve_q;
    owner_d       = OWNER_NONE;
    rom_addr_d    = rom_addr_q;
    ctl_d         = ctl_q;
    if (!reset) begin
      if (fetch_hit) begin
        data_win = bus.data_req;
        starve_d = '0;
      end else if (bus.fetch_req && bus.data_req) begin
        if (starve_q >= LIMIT) begin
          fetch_rom_win = 1'b1;
          starve_d      = '0;
        end else begin
          data_win = 1'b1;
          starve_d = starve_q + STARVE_W'(1);
        end
      end else begin
        fetch_rom_win = bus.fetch_req;
        data_win      = bus.data_req;
        starve_d      = '0;
      end
    end
    if (fetch_rom_win) begin
      owner_d    = OWNER_FETCH;
      rom_addr_d = bus.fetch_addr;
    end
    if (data_win) begin
      owner_d    = OWNER_DATA;
      rom_addr_d = bus.data_addr;
      ctl_d      = '{lane: bus.data_addr[1:0], size: bus.data_size, sext: bus.data_signed};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q      <= OWNER_NONE;
      starve_q     <= '0;
      rom_addr_q   <= '0;
      ctl_q        <= '0;
      fetch_hold_q <= '0;
      data_hold_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      rom_addr_q <= rom_addr_d;
      ctl_q      <= ctl_d;
      if (fetch_ret) fetch_hold_q <= fetch_src;
      if (data_ret)  data_hold_q  <= load_word;
    end
  end

  rom_load_align u_align (
    .word_i    (bus.rom_data_in),
    .addr_lo_i (ctl_q.lane),
    .size_i    (ctl_q.size),
    .signed_i  (ctl_q.sext),
    .rdata_o   (load_word)
  );

  // The ROM output register supplies return data; hold registers keep it between pulses.
  assign bus.fetch_grant = fetch_rom_win | fetch_hit;
  assign bus.data_grant  = data_win;
  assign bus.rom_address = rom_addr_d;
  assign bus.fetch_valid = fetch_ret;
  assign bus.data_valid  = data_ret;
  assign bus.fetch_data  = fetch_ret ? fetch_src : fetch_hold_q;
  assign bus.data_rdata  = data_ret ? load_word : data_hold_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a behavioural ROM plus a transaction-level model checked
// every cycle, and directed scenarios with literal expectations.
module tb_rom_arbiter;

  localparam int unsigned ADDR_W       = 10;
  localparam int          STARVE_LIMIT = 3;
`ifdef ROM_FETCH_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  rom_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  rom_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) bus.rom_data_in <= mem[bus.rom_address[9:2]];

  int n_chk = 0;
  int n_err = 0;
  bit rec   = 1'b0;
  int glog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] lo,
                                      input logic [1:0] sz, input logic sg);
    int nb, sh;
    logic [31:0] v, mask;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (nb == 1)      sh = 8 * int'(lo);
    else if (nb == 2) sh = 16 * int'(lo[1]);
    else              sh = 0;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    v = (w >> sh) & mask;
    if (sg && nb < 4 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // Transaction-level model state
  bit          m_fret = 0, m_fret_rom = 0, m_dret = 0, m_last_ok = 0, m_cv = 0;
  int          m_starve = 0;
  logic [31:0] m_fdata = '0, m_ddata = '0, m_fhold = '0, m_dhold = '0, m_cdata = '0;
  logic [7:0]  m_ftag = '0, m_ctag = '0;
  logic [9:0]  m_last = '0;

  always @(negedge clk) begin : cmp
    bit          ev_f, ev_d, fill, hit, eg_f, eg_d, fr, dr;
    logic [7:0]  fill_tag;
    logic [31:0] fill_data;
    fr = bus.fetch_req;
    dr = bus.data_req;
    ev_f = !reset && m_fret;
    ev_d = !reset && m_dret;
    fill = ev_f && m_fret_rom;
    fill_tag  = m_ftag;
    fill_data = m_fdata;
    if (ev_f) m_fhold = m_fdata;
    if (ev_d) m_dhold = m_ddata;
    chk("fetch_valid", 32'(bus.fetch_valid), 32'(ev_f));
    chk("data_valid",  32'(bus.data_valid),  32'(ev_d));
    chk("fetch_data",  bus.fetch_data, m_fhold);
    chk("data_rdata",  bus.data_rdata, m_dhold);

    hit  = CACHE_EN && !reset && fr && m_cv && (m_ctag == bus.fetch_addr[9:2]);
    eg_f = 1'b0;
    eg_d = 1'b0;
    if (!reset) begin
      if (hit) begin
        eg_f = 1'b1;
        eg_d = dr;
      end else if (fr && dr) begin
        if (m_starve >= STARVE_LIMIT) eg_f = 1'b1;
        else eg_d = 1'b1;
      end else begin
        eg_f = fr;
        eg_d = dr;
      end
    end
    chk("fetch_grant", 32'(bus.fetch_grant), 32'(eg_f));
    chk("data_grant",  32'(bus.data_grant),  32'(eg_d));
    if (eg_d) begin
      chk("rom_address_data", 32'(bus.rom_address), 32'(bus.data_addr));
      m_last = bus.data_addr; m_last_ok = 1'b1;
    end else if (eg_f && !hit) begin
      chk("rom_address_fetch", 32'(bus.rom_address), 32'(bus.fetch_addr));
      m_last = bus.fetch_addr; m_last_ok = 1'b1;
    end else if (m_last_ok) begin
      chk("rom_address_hold", 32'(bus.rom_address), 32'(m_last));
    end
    if (rec) glog.push_back(bus.fetch_grant ? 1 : (bus.data_grant ? 2 : 0));

    if (reset || !fr || eg_f) m_starve = 0;
    else if (eg_d) m_starve = m_starve + 1;
    m_fret     = eg_f;
    m_fret_rom = eg_f && !hit;
    m_fdata    = hit ? m_cdata : mem[bus.fetch_addr[9:2]];
    m_ftag     = bus.fetch_addr[9:2];
    m_dret     = eg_d;
    m_ddata    = ext(mem[bus.data_addr[9:2]], bus.data_addr[1:0], bus.data_size, bus.data_signed);
    if (fill) begin
      m_cv = 1'b1; m_ctag = fill_tag; m_cdata = fill_data;
    end
    if (reset) begin
      m_fret = 0; m_fret_rom = 0; m_dret = 0; m_starve = 0;
      m_fhold = '0; m_dhold = '0; m_last_ok = 0; m_cv = 0;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string name, input logic [9:0] a, input logic [1:0] sz,
                         input logic sg, input logic [31:0] exp);
    bus.data_req = 1'b1; bus.data_addr = a; bus.data_size = sz; bus.data_signed = sg;
    @(negedge clk);
    chk({name, "_grant"}, 32'(bus.data_grant), 32'd1);
    step;
    bus.data_req = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, 32'(bus.data_valid), 32'd1);
    chk(name, bus.data_rdata, exp);
    step;
  endtask

  // Both requesters held; fetch moves to the next word after each fetch grant.
  task automatic both_held(input int cycles);
    bit g;
    bus.fetch_req = 1'b1; bus.data_req = 1'b1;
    rec = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      g = bus.fetch_grant;
      step;
      if (g) bus.fetch_addr = bus.fetch_addr + 10'h004;
    end
    rec = 1'b0;
    bus.fetch_req = 1'b0; bus.data_req = 1'b0;
  endtask

  task automatic check_pattern(input string name, input int cycles);
    chk({name, "_len"}, 32'(glog.size()), 32'(cycles));
    for (int i = 0; i < cycles && i < glog.size(); i++)
      chk(name, 32'(glog[i]), (i % 4 == 3) ? 32'd1 : 32'd2);
    glog.delete();
  endtask

  initial begin
    int  n;
    bit  got;
    for (int i = 0; i < 256; i++) mem[i] = {16'hC0DE, 16'(i)};
    mem[0] = 32'h8899_AABB;
    reset = 1'b1;
    bus.fetch_req = 1'b0; bus.fetch_addr = '0;
    bus.data_req = 1'b0; bus.data_addr = '0; bus.data_size = 2'd2; bus.data_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    chk("rst_data_valid",  32'(bus.data_valid),  32'd0);
    chk("rst_fetch_data",  bus.fetch_data, 32'd0);
    chk("rst_data_rdata",  bus.data_rdata, 32'd0);
    step;
    reset = 1'b0;

    // Single fetch of word 4
    bus.fetch_req = 1'b1; bus.fetch_addr = 10'h010;
    @(negedge clk);
    chk("t1_grant", 32'(bus.fetch_grant), 32'd1);
    chk("t1_addr",  32'(bus.rom_address), 32'h010);
    step;
    bus.fetch_req = 1'b0;
    @(negedge clk);
    chk("t1_valid", 32'(bus.fetch_valid), 32'd1);
    chk("t1_data",  bus.fetch_data, 32'hC0DE_0004);
    step;
    @(negedge clk);
    chk("t1_hold", bus.fetch_data, 32'hC0DE_0004);
    step;

    // Starvation pattern D,D,D,F,D,D,D,F
    bus.fetch_addr = 10'h014; bus.data_addr = 10'h018; bus.data_size = 2'd2;
    both_held(8);
    check_pattern("t2_pattern", 8);
    step;

    // Load extraction on word 0 = 0x8899AABB
    do_load("t3_b3_s", 10'h003, 2'd0, 1'b1, 32'hFFFF_FF88);
    do_load("t3_b0_u", 10'h000, 2'd0, 1'b0, 32'h0000_00BB);
    do_load("t3_b1_s", 10'h001, 2'd0, 1'b1, 32'hFFFF_FFAA);
    do_load("t3_h2_s", 10'h002, 2'd1, 1'b1, 32'hFFFF_8899);
    do_load("t3_h1_u", 10'h001, 2'd1, 1'b0, 32'h0000_AABB);
    do_load("t3_w3",   10'h002, 2'd3, 1'b1, 32'h8899_AABB);
    do_load("t3_w5",   10'h014, 2'd2, 1'b0, 32'hC0DE_0005);

    // Reset in the cycle after a data grant, with starve_cnt at 2
    bus.fetch_req = 1'b1; bus.fetch_addr = 10'h0F0;
    bus.data_req = 1'b1; bus.data_addr = 10'h000; bus.data_size = 2'd2; bus.data_signed = 1'b0;
    @(negedge clk);
    chk("t4_grant0", 32'(bus.data_grant), 32'd1);
    step;
    @(negedge clk);
    chk("t4_grant1", 32'(bus.data_grant), 32'd1);
    step;
    reset = 1'b1; bus.fetch_req = 1'b0; bus.data_req = 1'b0;
    @(negedge clk);
    chk("t4_no_valid", 32'(bus.data_valid), 32'd0);
    step;
    reset = 1'b0;
    @(negedge clk);
    chk("t4_rdata_zero", bus.data_rdata, 32'd0);
    chk("t4_fdata_zero", bus.fetch_data, 32'd0);
    step;
    both_held(4);
    check_pattern("t4_pattern", 4);
    step;

    // Fetch 0x020 twice with data_req held high
    bus.data_req = 1'b1; bus.data_addr = 10'h004; bus.data_size = 2'd2;
    bus.fetch_req = 1'b1; bus.fetch_addr = 10'h020;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.fetch_grant) begin
        got = 1'b1;
        break;
      end
      step;
    end
    chk("t5_first_grant", 32'(got), 32'd1);
    step;
    bus.fetch_req = 1'b0;
    step;
    bus.fetch_req = 1'b1;
    @(negedge clk);
`ifdef ROM_FETCH_CACHE_EN
    chk("t5_hit_fgrant", 32'(bus.fetch_grant), 32'd1);
    chk("t5_hit_dgrant", 32'(bus.data_grant), 32'd1);
    step;
    bus.fetch_req = 1'b0;
    @(negedge clk);
    chk("t5_fvalid", 32'(bus.fetch_valid), 32'd1);
    chk("t5_dvalid", 32'(bus.data_valid), 32'd1);
    chk("t5_fdata",  bus.fetch_data, 32'hC0DE_0008);
    chk("t5_ddata",  bus.data_rdata, 32'hC0DE_0001);
`else
    chk("t5_fgrant_wait", 32'(bus.fetch_grant), 32'd0);
    chk("t5_dgrant", 32'(bus.data_grant), 32'd1);
    n = 0;
    while (n < 10) begin
      step;
      n++;
      @(negedge clk);
      if (bus.fetch_grant) break;
    end
    chk("t5_starve_cycles", 32'(n), 32'd3);
    step;
    bus.fetch_req = 1'b0;
    @(negedge clk);
    chk("t5_fvalid", 32'(bus.fetch_valid), 32'd1);
    chk("t5_fdata",  bus.fetch_data, 32'hC0DE_0008);
`endif
    step;
    bus.data_req = 1'b0;
    repeat (3) step;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
